counter_seek_arb: RTL

COUNTER_SEEK_ARB -- requirements
Module: counter_seek_arb

---
 rtl/counter_seek_pkg.sv | 19 +
 rtl/updown_counter.sv | 33 +++
 rtl/counter_seek_arb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/counter_seek_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_seek_pkg
// Description : Shared FSM state encoding and default counter width for the
//               counter seek arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_seek_pkg;

    localparam int C_N_BITS_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : counter_seek_pkg
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter
// Description : Modulo 2**N_BITS position counter, steps +1/-1 when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter
    import counter_seek_pkg::*;
#(
    parameter int N_BITS = C_N_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    output logic [N_BITS-1:0] count
);

    // Wrap in both directions falls out of the N_BITS-wide arithmetic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (dir) begin
                count <= count + 1'b1;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule : updown_counter
`default_nettype wire

// File: rtl/counter_seek_arb.sv
`default_nettype none
// ============================================================================
// Module      : counter_seek_arb
// Description : Two-requester round-robin arbiter that seeks a modulo counter
//               to the granted target along the shorter direction.
//               Optional macro SEEK_ABORT_EN adds abort / done_aborted.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seek_arb
    import counter_seek_pkg::*;
#(
    parameter int N_BITS = C_N_BITS_DEFAULT,
    parameter bit TIE_UP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [N_BITS-1:0] req0_target,
    input  logic              req1_valid,
    input  logic [N_BITS-1:0] req1_target,
`ifdef SEEK_ABORT_EN
    input  logic              abort,
    output logic              done_aborted,
`endif
    output logic              req0_ready,
    output logic              req1_ready,
    output logic [N_BITS-1:0] pos,
    output logic              en,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              done_id
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_BITS-1:0]   r_target;
    logic                r_id;
    logic                r_rr_favour;
    logic                w_grant_valid;
    logic                w_grant_id;
    logic                w_accept;
    logic [N_BITS-1:0]   w_fwd;
    logic [N_BITS-1:0]   w_bwd;
    logic                w_dir;

    // Favoured requester wins only on contention; a lone request always wins.
    assign w_grant_valid = req0_valid | req1_valid;
    assign w_grant_id    = (req0_valid & req1_valid) ? r_rr_favour : req1_valid;

    assign w_fwd = r_target - pos;
    assign w_bwd = pos - r_target;
    assign w_dir = (w_fwd < w_bwd) ? 1'b1 :
                   (w_fwd > w_bwd) ? 1'b0 : TIE_UP;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        en          = 1'b0;
        dir         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_accept    = 1'b1;
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                    w_state_nxt = SEEK;
                end
            end
            SEEK: begin
                if (pos == r_target) begin
                    w_state_nxt = DONE;
                end else begin
                    en  = 1'b1;
                    dir = w_dir;
                end
`ifdef SEEK_ABORT_EN
                if (abort) begin
                    en          = 1'b0;
                    dir         = 1'b0;
                    w_state_nxt = DONE;
                end
`endif
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_target    <= '0;
            r_id        <= 1'b0;
            r_rr_favour <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_target    <= w_grant_id ? req1_target : req0_target;
                r_id        <= w_grant_id;
                r_rr_favour <= ~w_grant_id;
            end
        end
    end

`ifdef SEEK_ABORT_EN
    logic r_aborted;

    // The last SEEK cycle's abort value decides how the DONE pulse is tagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aborted <= 1'b0;
        end else if (r_state == SEEK) begin
            r_aborted <= abort;
        end
    end

    assign done_aborted = done & r_aborted;
`endif

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign done_id = done & r_id;

    updown_counter #(
        .N_BITS (N_BITS)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .dir   (dir),
        .count (pos)
    );

endmodule : counter_seek_arb
`default_nettype wire
